fp_compare_pipe: RTL
====================

Name: fp_compare_pipe

Overview:
- Parametrised, pipelined IEEE-754 comparison unit. It is the next generation of the single-function equality-compare wrapper.
- Supports five ops: EQ, LT, LE, MIN, MAX. Follows RISC-V F-extension semantics, including the invalid (NV) flag.
- Configurable format width and latency, valid/ready handshake with backpressure, and a tag carried alongside each operation.
- Sits in the FPU issue path beside the other FP pipelines. Implemented in plain RTL, no vendor IP.

Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 23, mantissa width. FW = 1+EXP_W+MAN_W.
- LATENCY, 1, pipeline stages from input acceptance to output; must be >= 1.
- TAG_W, 5, width of the opaque tag passed through.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation present.
- in_ready  out  1  unit can accept this cycle.
- op  in  3  0 EQ, 1 LT, 2 LE, 3 MIN, 4 MAX, 5-7 reserved.
- a  in  FW  operand A.
- b  in  FW  operand B.
- tag  in  TAG_W  opaque; returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- result  out  FW  compare ops: bit0 = outcome, upper bits 0. MIN/MAX: selected operand or canonical NaN.
- invalid  out  1  NV exception flag for this result.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
Reset
- While reset is low: all stage valid bits clear, so out_valid = 0.
- result, invalid and out_tag reset to 0.
- Asserting reset mid-operation discards every in-flight op; nothing is emitted after release.
- in_ready = 1 the first cycle after release.

Handshake
- Global stall enable: en = !out_valid || out_ready. in_ready = en.
- When en = 1, all LATENCY stages advance together.
- An input is accepted on in_valid && in_ready. Its result appears with out_valid exactly LATENCY cycles later, provided no stall occurred in between.
- While out_valid && !out_ready, every stage holds and the outputs are stable (no bubble collapse).
- Throughput is 1 op/cycle with out_ready held high.
- Bubbles propagate as invalid stages.

Classification, per operand
- NaN: exp all-ones and mantissa != 0.
- sNaN: NaN with mantissa MSB = 0.
- Zero: exp = 0 and mantissa = 0. +0 and -0 compare equal for EQ/LT/LE.
- Subnormals are compared exactly; no flush.

Ordering
- Magnitude compare on {exp, man}, combined with sign.
- Both negative: magnitude order inverts.

EQ
- result = a==b numerically; 0 if either operand is NaN.
- invalid = either operand is sNaN.

LT / LE
- result = a<b or a<=b; 0 if either operand is NaN.
- invalid = either operand is NaN (quiet or signalling).

MIN / MAX
- Returns the lesser / greater operand. For these ops -0 < +0.
- Exactly one NaN: return the other operand.
- Both NaN: return canonical NaN (sign 0, exp all-ones, mantissa MSB only; 0x7FC00000 for the defaults).
- invalid = either operand is sNaN.

Reserved ops
- result = 0, invalid = 0; the op still occupies a slot and returns its tag.

Pipeline
- All combinational work is in stage 1; stages 2..LATENCY are pure delay.

Test Plan:
- EQ, 0x3F800000 vs 0x3F800000, LATENCY=1, out_ready=1 -> result=1, invalid=0, out_valid exactly 1 cycle after acceptance, tag returned.
- EQ +0 (0x00000000) vs -0 (0x80000000) -> result=1. MIN of the same pair -> 0x80000000. MAX -> 0x00000000.
- LT with a=0x7FC00000 (qNaN), b=0x3F800000 -> result=0, invalid=1. EQ with the same operands -> result=0, invalid=0. EQ with a=0x7F800001 (sNaN) -> invalid=1.
- MIN with a=0x7F800001, b=0xC0000000 -> result=0xC0000000, invalid=1. MAX with both NaN -> result=0x7FC00000.
- LATENCY=3: issue 4 back-to-back ops with tags 1..4, then drop out_ready for 5 cycles mid-stream. Required: in_ready=0 while stalled, outputs held stable, results emerge in order 1..4 with none lost or duplicated.
- Assert reset low with 2 ops in flight, then release -> out_valid stays 0, and a following op completes normally after LATENCY cycles.

Source files
------------

// File: rtl/fp_compare_pipe.sv
// Pipelined IEEE-754 compare unit: EQ/LT/LE/MIN/MAX with RISC-V NV semantics.
// All arithmetic happens in stage 1; later stages only delay the result and tag.
module fp_compare_pipe #(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int LATENCY = 1,
    parameter int TAG_W   = 5,
    localparam int FW     = 1 + EXP_W + MAN_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [FW-1:0]    a,
    input  logic [FW-1:0]    b,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FW-1:0]    result,
    output logic             invalid,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] OP_EQ  = 3'd0;
    localparam logic [2:0] OP_LT  = 3'd1;
    localparam logic [2:0] OP_LE  = 3'd2;
    localparam logic [2:0] OP_MIN = 3'd3;
    localparam logic [2:0] OP_MAX = 3'd4;

    localparam logic [FW-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic             a_sign, b_sign;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_man, b_man;
    logic [FW-2:0]    a_mag, b_mag;
    logic             a_nan, b_nan, a_snan, b_snan, a_zero, b_zero;
    logic             mag_lt, mag_eq, mag_gt;
    logic             num_lt, num_eq, tot_lt;
    logic             any_nan, any_snan;
    logic [FW-1:0]    res_s1;
    logic             inv_s1;
    logic             en;

    assign a_sign = a[FW-1];
    assign b_sign = b[FW-1];
    assign a_exp  = a[FW-2:MAN_W];
    assign b_exp  = b[FW-2:MAN_W];
    assign a_man  = a[MAN_W-1:0];
    assign b_man  = b[MAN_W-1:0];
    assign a_mag  = a[FW-2:0];
    assign b_mag  = b[FW-2:0];

    assign a_nan  = (&a_exp) && (|a_man);
    assign b_nan  = (&b_exp) && (|b_man);
    assign a_snan = a_nan && !a_man[MAN_W-1];
    assign b_snan = b_nan && !b_man[MAN_W-1];
    assign a_zero = ~|a_mag;
    assign b_zero = ~|b_mag;

    assign any_nan  = a_nan || b_nan;
    assign any_snan = a_snan || b_snan;

    // {exp, man} is monotonic in magnitude, so one unsigned compare orders non-NaN values.
    assign mag_lt = a_mag < b_mag;
    assign mag_eq = a_mag == b_mag;
    assign mag_gt = !mag_lt && !mag_eq;

    always_comb begin
        num_eq = (a_zero && b_zero) || (a == b);

        if (a_zero && b_zero)
            num_lt = 1'b0;
        else if (a_sign != b_sign)
            num_lt = a_sign;
        else if (a_sign)
            num_lt = mag_gt;
        else
            num_lt = mag_lt;

        // Total order used by MIN/MAX: -0 sorts below +0.
        if (a_sign != b_sign)
            tot_lt = a_sign;
        else if (a_sign)
            tot_lt = mag_gt;
        else
            tot_lt = mag_lt;
    end

    always_comb begin
        res_s1 = '0;
        inv_s1 = 1'b0;
        case (op)
            OP_EQ: begin
                res_s1 = {{(FW-1){1'b0}}, num_eq && !any_nan};
                inv_s1 = any_snan;
            end
            OP_LT: begin
                res_s1 = {{(FW-1){1'b0}}, num_lt && !any_nan};
                inv_s1 = any_nan;
            end
            OP_LE: begin
                res_s1 = {{(FW-1){1'b0}}, (num_lt || num_eq) && !any_nan};
                inv_s1 = any_nan;
            end
            OP_MIN, OP_MAX: begin
                if (a_nan && b_nan)
                    res_s1 = CANON_NAN;
                else if (a_nan)
                    res_s1 = b;
                else if (b_nan)
                    res_s1 = a;
                else if (op == OP_MIN)
                    res_s1 = tot_lt ? a : b;
                else
                    res_s1 = tot_lt ? b : a;
                inv_s1 = any_snan;
            end
            default: begin
                res_s1 = '0;
                inv_s1 = 1'b0;
            end
        endcase
    end

    // Handshake: input transfers on in_valid && in_ready, output on out_valid && out_ready.
    // The whole pipe advances as one when the output slot is empty or being consumed.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    logic [LATENCY-1:0]            vld_d, vld_q;
    logic [LATENCY-1:0]            inv_d, inv_q;
    logic [LATENCY-1:0][FW-1:0]    res_d, res_q;
    logic [LATENCY-1:0][TAG_W-1:0] tag_d, tag_q;

    always_comb begin
        vld_d    = vld_q;
        inv_d    = inv_q;
        res_d    = res_q;
        tag_d    = tag_q;
        vld_d[0] = in_valid;
        inv_d[0] = inv_s1;
        res_d[0] = res_s1;
        tag_d[0] = tag;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            inv_d[i] = inv_q[i-1];
            res_d[i] = res_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            inv_q <= '0;
            res_q <= '0;
            tag_q <= '0;
        end else if (en) begin
            vld_q <= vld_d;
            inv_q <= inv_d;
            res_q <= res_d;
            tag_q <= tag_d;
        end
    end

    assign out_valid = vld_q[LATENCY-1];
    assign invalid   = inv_q[LATENCY-1];
    assign result    = res_q[LATENCY-1];
    assign out_tag   = tag_q[LATENCY-1];

endmodule
